decoder_pipe: RTL and testbench
===============================

# decoder_pipe

Parametrised, pipelined N-to-2^N one-hot decoder with valid/ready handshake. It generates register-file write-enable vectors from destination indices as they move through the CPU pipeline. Each index is held for a configurable number of register stages, with back-pressure and bubble collapsing. It can mask the hardwired-zero register so that writes to it never assert an enable.

## Interface
- IN_W, 5: index width; output width is 2**IN_W.
- STAGES, 2: pipeline register stages, legal range 1..8.
- MASK_ZERO, 1: when 1, index ZERO_IDX always decodes to all-zeros.
- ZERO_IDX, 31: index of the hardwired-zero register.
- CNT_W, $clog2(STAGES+1): width of the occupancy count (localparam).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input index valid.
- in_ready  out  1  stage 0 can accept this cycle.
- in_idx  in  IN_W  destination index.
- in_en  in  1  write enable; 0 produces an all-zero one-hot.
- out_valid  out  1  last stage holds a transaction.
- out_ready  in  1  downstream accepts.
- out_onehot  out  2**IN_W  decoded enable vector.
- out_idx  out  IN_W  index carried through the pipeline.
- out_masked  out  1  transaction decoded to all-zeros (in_en=0 or masked zero register).
- count  out  CNT_W  number of occupied stages.

## Operation
- STAGES registers, s[0]..s[STAGES-1]. Each holds {v, idx, en, masked}.
- masked = !in_en || (MASK_ZERO && in_idx==ZERO_IDX). It is computed once, at capture into s[0].
- Readiness chain: rdy[STAGES-1] = out_ready || !v[STAGES-1]; rdy[k] = !v[k] || rdy[k+1]; in_ready = rdy[0].
- Stage k loads s[k-1] when rdy[k]; s[0] loads the input when rdy[0].
  - A stage that loads while its source is invalid becomes a bubble (v=0).
  - Bubbles collapse: a stalled output lets upstream stages fill empty slots.
- Input accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
- out_valid = v[STAGES-1]; out_idx = idx[STAGES-1].
- out_onehot = (out_valid && !masked[STAGES-1]) ? (1 << idx[STAGES-1]) : 0. It is combinational from the last stage and has exactly one bit or zero bits set.
- out_masked = out_valid && masked[STAGES-1]; 0 when out_valid is 0.
- count = sum of v[k]. It is kept as a register and updated as +1 on accept only, -1 on transfer only, and unchanged when both or neither occur.
- Masked transactions still flow and still occupy a slot; only the one-hot is suppressed.
- Outputs are stable while out_valid && !out_ready. Downstream sees no change until transfer.

## Timing
- Reset (reset_n low, asynchronous):
  - All v cleared; idx, en and masked cleared.
  - out_valid=0, out_onehot=0, out_idx=0, out_masked=0, count=0.
  - in_ready is forced 0 while reset_n is low.
- in_ready returns to 1 in the first cycle after deassertion.
- Reset mid-operation: all in-flight transactions are dropped, with no partial output.
- Latency: an index accepted at edge t appears on out_valid after edge t+STAGES-1, so STAGES cycles of register delay. For STAGES=1, it is valid the cycle after acceptance.
- Throughput: one transaction per cycle while out_ready stays high.
- Full: count==STAGES and !out_ready gives in_ready=0.
- Full with out_ready=1: in_ready=1 in the same cycle, giving simultaneous accept and transfer with count unchanged.
- Empty: out_valid=0 and count=0. out_ready is ignored.
- in_ready depends combinationally on out_ready (a pass-through path exists). No other input-to-output combinational path exists except the decode from registered state.

## Structure
- A shared package decoder_pkg holds:
  - the stage struct typedef {v, idx, en, masked}, parameterised by IN_W via a parameterised-width typedef in the module;
  - the ZERO_IDX default;
  - a function onehot_f(idx, mask) returning the decoded vector.
- One sub-module is natural: decoder_stage, a single register slot with load/valid. It is instantiated STAGES times via generate.

## Test plan
- Reset, then IN_W=5, STAGES=2, in_idx=3, in_en=1, out_ready=1 -> out_valid after 2 edges, out_onehot=32'h0000_0008, out_masked=0, count back to 0.
- in_idx=31, MASK_ZERO=1 -> out_valid=1, out_onehot=0, out_masked=1. Repeat with MASK_ZERO=0 -> out_onehot=32'h8000_0000.
- Stream idx 0..9 back-to-back with out_ready=1 -> one output per cycle, in order, onehot=1<<idx, count steady at 2.
- Hold out_ready=0 and issue 3 indices -> first two accepted, in_ready=0, count=2. Raise out_ready for one cycle -> one transfer and one accept in the same cycle, count stays 2.
- Insert an input gap with out_ready=0 -> bubble collapses and both stages fill. Out_onehot stays stable until transfer.
- Assert reset_n low mid-stream with count=2 -> out_valid=0, out_onehot=0 and count=0 immediately (asynchronously). After release, first accepted index emerges with no stale data.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants and the one-hot decode helper for the destination-index decoder pipeline.
package decoder_pkg;

  localparam int DEF_IN_W     = 5;
  localparam int DEF_ZERO_IDX = 31;
  // Widest index the decode helper supports; callers zero-extend and truncate to their width.
  localparam int MAX_IN_W     = 8;

  function automatic logic [2**MAX_IN_W-1:0] onehot_f(input logic [MAX_IN_W-1:0] idx,
                                                      input logic                mask);
    logic [2**MAX_IN_W-1:0] vec;
    vec = '0;
    if (!mask) vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/decoder_stage.sv
// One pipeline slot: captures {v, idx, en, masked} from its source whenever it is told to load.
module decoder_stage
  import decoder_pkg::*;
#(
  parameter int IN_W = DEF_IN_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_load,
  input  logic            i_v,
  input  logic [IN_W-1:0] i_idx,
  input  logic            i_en,
  input  logic            i_masked,
  output logic            o_v,
  output logic [IN_W-1:0] o_idx,
  output logic            o_en,
  output logic            o_masked
);

  logic            r_v;
  logic [IN_W-1:0] r_idx;
  logic            r_en;
  logic            r_masked;

  // Loading from an invalid source leaves a bubble behind (v=0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v      <= 1'b0;
      r_idx    <= '0;
      r_en     <= 1'b0;
      r_masked <= 1'b0;
    end else if (i_load) begin
      r_v      <= i_v;
      r_idx    <= i_idx;
      r_en     <= i_en;
      r_masked <= i_masked;
    end
  end

  assign o_v      = r_v;
  assign o_idx    = r_idx;
  assign o_en     = r_en;
  assign o_masked = r_masked;

endmodule

// File: rtl/decoder_pipe.sv
// Pipelined N-to-2^N one-hot decoder producing register-file write enables, with
// valid/ready back-pressure, bubble collapsing and optional hardwired-zero masking.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int  IN_W      = DEF_IN_W,
  parameter int  STAGES    = 2,
  parameter bit  MASK_ZERO = 1'b1,
  parameter int  ZERO_IDX  = DEF_ZERO_IDX,
  localparam int CNT_W     = $clog2(STAGES + 1),
  localparam int OUT_W     = 2**IN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_idx,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic [IN_W-1:0]  out_idx,
  output logic             out_masked,
  output logic [CNT_W-1:0] count
);

  typedef struct packed {
    logic            v;
    logic [IN_W-1:0] idx;
    logic            en;
    logic            masked;
  } stage_t;

  logic [STAGES-1:0] w_srcV;
  logic [STAGES-1:0] w_srcEn;
  logic [STAGES-1:0] w_srcMasked;
  logic [IN_W-1:0]   w_srcIdx [STAGES];
  logic [STAGES-1:0] w_v;
  logic [STAGES-1:0] w_en;
  logic [STAGES-1:0] w_masked;
  logic [IN_W-1:0]   w_idx [STAGES];
  logic [STAGES-1:0] w_rdy;
  logic              w_inMasked;
  logic              w_accept;
  logic              w_transfer;
  stage_t            w_last;
  logic [CNT_W-1:0]  r_count;

  assign w_inMasked = !in_en || (MASK_ZERO && (in_idx == IN_W'(ZERO_IDX)));

  // A stage may load if it or any stage below it is empty, or the output drains this cycle.
  always_comb begin
    logic w_allValid;
    w_rdy = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_allValid = 1'b1;
      for (int j = k; j < STAGES; j++) w_allValid = w_allValid & w_v[j];
      w_rdy[k] = !w_allValid || out_ready;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_srcV[k]      = in_valid;
      assign w_srcIdx[k]    = in_idx;
      assign w_srcEn[k]     = in_en;
      assign w_srcMasked[k] = w_inMasked;
    end else begin : g_link
      assign w_srcV[k]      = w_v[k-1];
      assign w_srcIdx[k]    = w_idx[k-1];
      assign w_srcEn[k]     = w_en[k-1];
      assign w_srcMasked[k] = w_masked[k-1];
    end

    decoder_stage #(.IN_W(IN_W)) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_load   (w_rdy[k]),
      .i_v      (w_srcV[k]),
      .i_idx    (w_srcIdx[k]),
      .i_en     (w_srcEn[k]),
      .i_masked (w_srcMasked[k]),
      .o_v      (w_v[k]),
      .o_idx    (w_idx[k]),
      .o_en     (w_en[k]),
      .o_masked (w_masked[k])
    );
  end

  assign w_last = '{v: w_v[STAGES-1], idx: w_idx[STAGES-1],
                    en: w_en[STAGES-1], masked: w_masked[STAGES-1]};

  assign in_ready   = w_rdy[0] && reset_n;
  assign w_accept   = in_valid && in_ready;
  assign w_transfer = w_last.v && out_ready;

  // Occupancy moves only when exactly one of accept/transfer happens.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      case ({w_accept, w_transfer})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count      = r_count;
  assign out_valid  = w_last.v;
  assign out_idx    = w_last.idx;
  assign out_masked = w_last.v && w_last.masked;
  assign out_onehot = OUT_W'(onehot_f(MAX_IN_W'(w_last.idx),
                                      !w_last.v || w_last.masked || !w_last.en));

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed self-checking bench: default 2-stage masking decoder plus a 1-stage unmasked instance.
module tb_decoder_pipe;

  logic        clk;
  logic        reset_n;

  logic        inValid, inReady, inEn, outValid, outReady, outMasked;
  logic [4:0]  inIdx, outIdx;
  logic [31:0] outOnehot;
  logic [1:0]  count0;

  logic        inValid1, inReady1, inEn1, outValid1, outReady1, outMasked1;
  logic [4:0]  inIdx1, outIdx1;
  logic [31:0] outOnehot1;
  logic [0:0]  count1;

  int numChecks = 0;
  int numFails  = 0;

  decoder_pipe #(.IN_W(5), .STAGES(2), .MASK_ZERO(1'b1), .ZERO_IDX(31)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(inValid), .in_ready(inReady), .in_idx(inIdx), .in_en(inEn),
    .out_valid(outValid), .out_ready(outReady), .out_onehot(outOnehot),
    .out_idx(outIdx), .out_masked(outMasked), .count(count0)
  );

  decoder_pipe #(.IN_W(5), .STAGES(1), .MASK_ZERO(1'b0), .ZERO_IDX(31)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(inValid1), .in_ready(inReady1), .in_idx(inIdx1), .in_en(inEn1),
    .out_valid(outValid1), .out_ready(outReady1), .out_onehot(outOnehot1),
    .out_idx(outIdx1), .out_masked(outMasked1), .count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives dut0 inputs just after an edge and lets combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [4:0] idx, input logic en, input logic ordy);
    inValid  = v;
    inIdx    = idx;
    inEn     = en;
    outReady = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    inValid   = 1'b0; inIdx  = '0; inEn  = 1'b0; outReady  = 1'b0;
    inValid1  = 1'b0; inIdx1 = '0; inEn1 = 1'b0; outReady1 = 1'b0;
    #2;
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_onehot",    outOnehot,     32'd0);
    checkOutput("rst_out_idx",   32'(outIdx),   32'd0);
    checkOutput("rst_masked",    32'(outMasked), 32'd0);
    checkOutput("rst_count",     32'(count0),   32'd0);
    checkOutput("rst_in_ready",  32'(inReady),  32'd0);
    checkOutput("rst_in_ready1", 32'(inReady1), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 32'(inReady), 32'd1);

    // Single-stage, unmasked instance: index 31 decodes normally one cycle later.
    inValid1 = 1'b1; inIdx1 = 5'd31; inEn1 = 1'b1; outReady1 = 1'b1;
    #1;
    checkOutput("s1_in_ready", 32'(inReady1), 32'd1);
    tick();
    inValid1 = 1'b0;
    #1;
    checkOutput("s1_out_valid", 32'(outValid1),  32'd1);
    checkOutput("s1_onehot31",  outOnehot1,      32'h8000_0000);
    checkOutput("s1_masked",    32'(outMasked1), 32'd0);
    checkOutput("s1_count",     32'(count1),     32'd1);
    tick();
    checkOutput("s1_drained",   32'(outValid1),  32'd0);
    checkOutput("s1_count0",    32'(count1),     32'd0);

    // Single index 3 through two stages.
    applyStimulus(1'b1, 5'd3, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("idx3_not_yet", 32'(outValid), 32'd0);
    tick();
    checkOutput("idx3_valid",  32'(outValid),  32'd1);
    checkOutput("idx3_onehot", outOnehot,      32'h0000_0008);
    checkOutput("idx3_masked", 32'(outMasked), 32'd0);
    checkOutput("idx3_count",  32'(count0),    32'd1);
    tick();
    checkOutput("idx3_drain_valid", 32'(outValid), 32'd0);
    checkOutput("idx3_drain_count", 32'(count0),   32'd0);

    // Zero register masked, then a write with en=0.
    applyStimulus(1'b1, 5'd31, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd7, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("zero_valid",  32'(outValid),  32'd1);
    checkOutput("zero_idx",    32'(outIdx),    32'd31);
    checkOutput("zero_onehot", outOnehot,      32'd0);
    checkOutput("zero_masked", 32'(outMasked), 32'd1);
    tick();
    checkOutput("en0_idx",    32'(outIdx),    32'd7);
    checkOutput("en0_onehot", outOnehot,      32'd0);
    checkOutput("en0_masked", 32'(outMasked), 32'd1);
    tick();
    checkOutput("en0_drained", 32'(outValid), 32'd0);

    // Back-to-back stream 0..9 at full throughput.
    for (int i = 0; i < 12; i++) begin
      if (i < 10) applyStimulus(1'b1, 5'(i), 1'b1, 1'b1);
      else        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
      tick();
      if (i >= 1 && i <= 10) begin
        checkOutput($sformatf("stream_valid_%0d", i - 1), 32'(outValid), 32'd1);
        checkOutput($sformatf("stream_idx_%0d", i - 1), 32'(outIdx), 32'(i - 1));
        checkOutput($sformatf("stream_onehot_%0d", i - 1), outOnehot, 32'(1 << (i - 1)));
      end
      if (i >= 1 && i <= 9) checkOutput($sformatf("stream_count_%0d", i), 32'(count0), 32'd2);
      if (i == 11) begin
        checkOutput("stream_end_valid", 32'(outValid), 32'd0);
        checkOutput("stream_end_count", 32'(count0),   32'd0);
      end
    end

    // Back-pressure: fill both stages, third index refused until out_ready rises.
    applyStimulus(1'b1, 5'd10, 1'b1, 1'b0);
    checkOutput("bp_ready_a", 32'(inReady), 32'd1);
    tick();
    applyStimulus(1'b1, 5'd11, 1'b1, 1'b0);
    checkOutput("bp_ready_b", 32'(inReady), 32'd1);
    tick();
    applyStimulus(1'b1, 5'd12, 1'b1, 1'b0);
    checkOutput("bp_full_ready", 32'(inReady), 32'd0);
    checkOutput("bp_full_count", 32'(count0),  32'd2);
    checkOutput("bp_full_idx",   32'(outIdx),  32'd10);
    tick();
    checkOutput("bp_hold_idx",    32'(outIdx), 32'd10);
    checkOutput("bp_hold_onehot", outOnehot,   32'h0000_0400);
    checkOutput("bp_hold_count",  32'(count0), 32'd2);
    applyStimulus(1'b1, 5'd12, 1'b1, 1'b1);
    checkOutput("bp_passthru_ready", 32'(inReady), 32'd1);
    tick();
    checkOutput("bp_swap_count",  32'(count0), 32'd2);
    checkOutput("bp_swap_idx",    32'(outIdx), 32'd11);
    checkOutput("bp_swap_onehot", outOnehot,   32'h0000_0800);

    // Drain one, leave a gap, then refill: the empty slot is reclaimed under a stalled output.
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    checkOutput("gap_idx",   32'(outIdx), 32'd12);
    checkOutput("gap_count", 32'(count0), 32'd1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    checkOutput("gap_ready", 32'(inReady), 32'd1);
    applyStimulus(1'b1, 5'd13, 1'b1, 1'b0);
    tick();
    checkOutput("fill_count",  32'(count0),  32'd2);
    checkOutput("fill_ready",  32'(inReady), 32'd0);
    checkOutput("fill_idx",    32'(outIdx),  32'd12);
    checkOutput("fill_onehot", outOnehot,    32'h0000_1000);

    // Asynchronous reset with both stages occupied.
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid",  32'(outValid), 32'd0);
    checkOutput("mid_rst_onehot", outOnehot,     32'd0);
    checkOutput("mid_rst_count",  32'(count0),   32'd0);
    checkOutput("mid_rst_ready",  32'(inReady),  32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    checkOutput("rel_ready", 32'(inReady), 32'd1);
    applyStimulus(1'b1, 5'd20, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("rel_no_stale", 32'(outValid), 32'd0);
    tick();
    checkOutput("rel_valid",  32'(outValid), 32'd1);
    checkOutput("rel_idx",    32'(outIdx),   32'd20);
    checkOutput("rel_onehot", outOnehot,     32'h0010_0000);
    tick();
    checkOutput("rel_drained", 32'(count0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChecks, numFails);
    $finish;
  end

endmodule
